// File: rtl/writeback_stage.sv
// writeback_stage -- final pipeline stage: selects the retiring result and
// drives the register-file write port.
//
// Non-load instructions retire in one cycle (ALU result or PC+4), allowing one
// retire per cycle. Loads park the stage until the data memory returns the
// word, which is then byte/half extracted and sign/zero extended.
//
// Ports
//   clk, reset_n                   clock, async active-low reset
//   in_valid / in_ready            handshake from the MEM stage
//   in_rd_we, in_rd_addr           destination register write enable / index
//   in_wb_sel                      00 ALU, 01 load, 10 PC+4, 11 treated as ALU
//   in_alu_result, in_pc_plus4     candidate results
//   in_ld_funct3, in_ld_byte_off   load type and address bits [1:0]
//   dmem_rvalid, dmem_rdata        load data return (one-cycle pulse)
//   rf_wr_en, rf_addr_rd, rf_data_rd  register-file write port (registered)
//   busy                           high while waiting for load data
//
// State      | meaning
// -----------+------------------------------------------------------------
// IDLE       | ready for an instruction; non-loads retire straight from here
// WAIT_LOAD  | load accepted, waiting for dmem_rvalid (no timeout)

module writeback_stage #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int REG_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_rd_we,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd_addr,
    input  logic [1:0]                in_wb_sel,
    input  logic [REG_WIDTH-1:0]      in_alu_result,
    input  logic [REG_WIDTH-1:0]      in_pc_plus4,
    input  logic [2:0]                in_ld_funct3,
    input  logic [1:0]                in_ld_byte_off,
    input  logic                      dmem_rvalid,
    input  logic [REG_WIDTH-1:0]      dmem_rdata,
    output logic                      rf_wr_en,
    output logic [REG_ADDR_WIDTH-1:0] rf_addr_rd,
    output logic [REG_WIDTH-1:0]      rf_data_rd,
    output logic                      busy
);

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic                        rd_we_q, rd_we_d;
    logic [REG_ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [2:0]                  funct3_q, funct3_d;
    logic [1:0]                  byte_off_q, byte_off_d;
    logic                        in_ready_q, in_ready_d;
    logic                        busy_q, busy_d;
    logic                        rf_wr_en_q, rf_wr_en_d;
    logic [REG_ADDR_WIDTH-1:0]   rf_addr_q, rf_addr_d;
    logic [REG_WIDTH-1:0]        rf_data_q, rf_data_d;

    logic                        accept;
    logic                        is_load;
    logic [7:0]                  ld_byte;
    logic [15:0]                 ld_half;
    logic [REG_WIDTH-1:0]        ld_data;

    // Handshake uses the registered ready, so nothing is accepted during
    // reset or in the first edge after it.
    assign accept  = in_valid & in_ready_q;
    assign is_load = (in_wb_sel == 2'b01);

    // Extraction works from the captured funct3/byte_off, since the MEM stage
    // has moved on by the time the data arrives. byte_off[0] is ignored for
    // halfwords.
    always_comb begin
        ld_byte = dmem_rdata[{byte_off_q, 3'b000} +: 8];
        ld_half = byte_off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_data = {{(REG_WIDTH-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{(REG_WIDTH-16){ld_half[15]}}, ld_half};
            3'b100:  ld_data = {{(REG_WIDTH-8){1'b0}}, ld_byte};
            3'b101:  ld_data = {{(REG_WIDTH-16){1'b0}}, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        rd_we_d    = rd_we_q;
        rd_addr_d  = rd_addr_q;
        funct3_d   = funct3_q;
        byte_off_d = byte_off_q;
        rf_wr_en_d = 1'b0;
        rf_addr_d  = rf_addr_q;
        rf_data_d  = rf_data_q;

        case (state_q)
            IDLE: begin
                // dmem_rvalid is deliberately not looked at here.
                if (accept) begin
                    rd_we_d    = in_rd_we;
                    rd_addr_d  = in_rd_addr;
                    funct3_d   = in_ld_funct3;
                    byte_off_d = in_ld_byte_off;
                    if (is_load) begin
                        state_d = WAIT_LOAD;
                    end else if (in_rd_we && (in_rd_addr != '0)) begin
                        rf_wr_en_d = 1'b1;
                        rf_addr_d  = in_rd_addr;
                        rf_data_d  = (in_wb_sel == 2'b10) ? in_pc_plus4 : in_alu_result;
                    end
                end
            end
            WAIT_LOAD: begin
                if (dmem_rvalid) begin
                    state_d = IDLE;
                    if (rd_we_q && (rd_addr_q != '0)) begin
                        rf_wr_en_d = 1'b1;
                        rf_addr_d  = rd_addr_q;
                        rf_data_d  = ld_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d == WAIT_LOAD);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rd_we_q    <= 1'b0;
            rd_addr_q  <= '0;
            funct3_q   <= '0;
            byte_off_q <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            rf_wr_en_q <= 1'b0;
            rf_addr_q  <= '0;
            rf_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            rd_we_q    <= rd_we_d;
            rd_addr_q  <= rd_addr_d;
            funct3_q   <= funct3_d;
            byte_off_q <= byte_off_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            rf_wr_en_q <= rf_wr_en_d;
            rf_addr_q  <= rf_addr_d;
            rf_data_q  <= rf_data_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign rf_wr_en   = rf_wr_en_q;
    assign rf_addr_rd = rf_addr_q;
    assign rf_data_rd = rf_data_q;

endmodule
